sha256_stream_hasher: RTL
=========================

# sha256_stream_hasher

Streaming SHA-256 front end that takes a message as a valid/ready byte stream `BYTES_PER_BEAT` bytes wide, performs FIPS 180-4 padding and block chaining, and presents each 256-bit digest on a valid/ready output port. It drives one internal `sha256_core` (start / block_in / hash_init / use_init / hash_out / ready). It accepts back-to-back messages with no software `start`, and supports partial final beats, empty messages and output backpressure.

## Interface
- `BYTES_PER_BEAT`, 4: input width in bytes; legal values are 1, 2, 4, 8 (must divide 64).
- `LEN_W`, 64: width of the message bit counter (≤64); the length field is zero-extended to 64 bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high; clock `clk`.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  8*BYTES_PER_BEAT  message bytes; the first byte is in the MSBs.
- `in_last`  in  1  this beat ends the message.
- `in_nbytes`  in  $clog2(BYTES_PER_BEAT)+1  count of valid bytes on the last beat, in the range 0..BYTES_PER_BEAT. Ignored unless `in_last`.
- `out_valid`  out  1  digest available.
- `out_ready`  in  1  digest consumed when `out_valid && out_ready`.
- `out_hash`  out  256  digest as H0..H7, with H0 in `[255:224]`.
- `busy`  out  1  high in any state other than LOAD with byte count 0.

## Operation
- States:
  - LOAD: accept beats.
  - PAD: build the final block.
  - HASH: wait on the core.
  - LEN: build the extra length-only block.
  - OUT: present the digest.
- LOAD:
  - `in_ready=1`.
  - Each accepted beat writes its bytes at byte offset `byte_cnt`, big-endian within the 512-bit block.
  - `byte_cnt` advances by `BYTES_PER_BEAT`, or by the clamped `in_nbytes` on a last beat.
  - `bit_cnt` advances by 8× the bytes taken, modulo 2^LEN_W.
- `in_nbytes` rules on a last beat:
  - 0 contributes no bytes, which allows an empty message.
  - Values greater than `BYTES_PER_BEAT` are clamped to `BYTES_PER_BEAT`.
  - Bytes beyond the valid count are don't-care.
- Non-last beat that fills the block (`byte_cnt` reaches 64): go to HASH; `byte_cnt` returns to 0.
- Last beat: go to PAD with `n` = bytes in the current block (0..64).
- PAD takes exactly one cycle:
  - If `n=64`: hash the block unchanged, then LEN.
  - Else: byte `n` = 0x80, bytes `n+1..63` = 0x00.
  - If additionally `n ≤ 55`: bytes 56..63 = `bit_cnt` as 64-bit big-endian; this is the final block.
  - If `56 ≤ n ≤ 63`: an extra block is needed; it holds only zeros plus the length.
- LEN takes one cycle and builds the extra block:
  - If the previous block was full (`n=64`): 0x80 at byte 0, zeros, length at bytes 56..63.
  - Otherwise: all zeros plus the length.
  - Then HASH.
- HASH:
  - A one-cycle `core_start` pulse with `hash_init=H`, `use_init=1`, `block_in=buffer`.
  - Completion is detected on the rising edge of core `ready`; the core's output includes the feed-forward addition.
  - On completion, `H` takes the core output.
  - Next state is LOAD, LEN or OUT depending on pending work.
- OUT:
  - `out_valid=1`; `out_hash` is held stable until the handshake.
  - On the handshake: `H` is reloaded with the IV `6a09e667…5be0cd19`, `bit_cnt=0`, `byte_cnt=0`, then LOAD.
- The core start pulse fires only when the core is idle. A new block is never issued before the previous block's completion edge.

## Timing
- Values held during reset and on the first cycle after it: `in_ready=0`, `out_valid=0`, `out_hash=0`, `busy=0`, `core_start=0`. State after reset is LOAD with `H`=IV.
- `in_ready` is a registered-state decode: it is high only in LOAD and low during reset.
- Throughput: one beat per cycle in LOAD, so a block takes 64/BYTES_PER_BEAT cycles.
- Latency, with the last beat accepted at cycle t:
  - PAD at t+1.
  - `core_start` at t+2.
  - `out_valid` on the cycle after the final core completion edge.
- An `out_valid && out_ready` handshake at cycle c gives `in_ready=1` at c+1.
- `rst` mid-message or mid-hash aborts the message: partial data is discarded, `H` returns to IV, and a completion edge arriving later is ignored.
- `out_ready` held low: `out_valid` and `out_hash` are held indefinitely and `in_ready` stays 0.

## Test plan
- Configuration: `BYTES_PER_BEAT=4`.
  - Stimulus: one beat `0x61626300` with `in_last=1`, `in_nbytes=3` ("abc").
  - Required: `out_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad`; exactly one core start.
- Empty message:
  - Stimulus: one beat with `in_last=1`, `in_nbytes=0`.
  - Required: `out_hash=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855`.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Stimulus: 14 beats, the last with `in_nbytes=4`.
  - Required: `out_hash=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1`; exactly 2 core starts.
- 64 × 'a' (exactly one full block):
  - Required: `out_hash=ffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb`; 2 core starts; the second block begins with 0x80.
- Back-to-back "abc" twice with `out_ready` held low for 20 cycles:
  - Required: the first digest is held stable and `in_ready=0` throughout.
  - Required: both digests equal the "abc" value, which proves the IV reload.
- Reset mid-message:
  - Stimulus: 40 bytes of 'a', then `rst` for 1 cycle, then "abc".
  - Required: the only digest output is the "abc" value.

Source files
------------

// File: rtl/sha256_stream_hasher.sv
// Streaming SHA-256 front end: byte stream in, padding and block chaining, digest out.
// Holds its own iterative compression core that runs one round per cycle.
module sha256_stream_hasher #(
    parameter int unsigned BYTES_PER_BEAT = 4,
    parameter int unsigned LEN_W          = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [8*BYTES_PER_BEAT-1:0]     in_data,
    input  logic                            in_last,
    input  logic [$clog2(BYTES_PER_BEAT):0] in_nbytes,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [255:0]                    out_hash,
    output logic                            busy
);
    localparam int unsigned NbW = $clog2(BYTES_PER_BEAT) + 1;
    localparam logic [255:0] Iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {StLoad, StPad, StHash, StLen, StOut} state_e;

    state_e           state_q, state_d;
    logic [7:0]       blk_q [64];
    logic [7:0]       blk_d [64];
    logic [255:0]     h_q, h_d;
    logic [6:0]       byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             final_q, final_d, len_pend_q, len_pend_d;
    logic             full_prev_q, full_prev_d, issued_q, issued_d, in_ready_q;
    logic [NbW-1:0]   nb_clamp;
    logic [6:0]       take;
    logic [5:0]       idx;
    logic [63:0]      len64;
    logic [8*BYTES_PER_BEAT-1:0] beat_sh;

    logic         core_start, core_ready, core_done, core_run_q, ready_prev_q;
    logic [5:0]   round_q;
    logic [31:0]  v_q [8];
    logic [31:0]  v_d [8];
    logic [31:0]  win_q [16];
    logic [31:0]  w_new, t1, t2;
    logic [511:0] core_block;
    logic [255:0] core_init, core_out;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign nb_clamp  = (in_nbytes > NbW'(BYTES_PER_BEAT)) ? NbW'(BYTES_PER_BEAT) : in_nbytes;
    assign len64     = 64'(bit_cnt_q);
    assign core_init = h_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            h_q         <= Iv;
            byte_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            final_q     <= 1'b0;
            len_pend_q  <= 1'b0;
            full_prev_q <= 1'b0;
            issued_q    <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            byte_cnt_q  <= byte_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            final_q     <= final_d;
            len_pend_q  <= len_pend_d;
            full_prev_q <= full_prev_d;
            issued_q    <= issued_d;
            in_ready_q  <= (state_d == StLoad);
            blk_q       <= blk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        blk_d       = blk_q;
        byte_cnt_d  = byte_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        final_d     = final_q;
        len_pend_d  = len_pend_q;
        full_prev_d = full_prev_q;
        issued_d    = issued_q;
        take        = '0;
        idx         = '0;
        beat_sh     = '0;
        unique case (state_q)
            StLoad: if (in_valid && in_ready_q) begin
                take = in_last ? 7'(nb_clamp) : 7'(BYTES_PER_BEAT);
                for (int j = 0; j < BYTES_PER_BEAT; j++) begin
                    if (7'(j) < take) begin
                        idx        = byte_cnt_q[5:0] + 6'(j);
                        beat_sh    = in_data << (8 * j);
                        blk_d[idx] = beat_sh[8*BYTES_PER_BEAT-1 -: 8];
                    end
                end
                byte_cnt_d = byte_cnt_q + take;
                bit_cnt_d  = bit_cnt_q + LEN_W'({take, 3'b000});
                if (in_last) begin
                    state_d = StPad;
                end else if (byte_cnt_d == 7'd64) begin
                    byte_cnt_d = '0;
                    final_d    = 1'b0;
                    len_pend_d = 1'b0;
                    state_d    = StHash;
                end
            end
            StPad: begin
                final_d     = 1'b0;
                len_pend_d  = 1'b1;
                full_prev_d = byte_cnt_q[6];
                if (!byte_cnt_q[6]) begin
                    for (int i = 0; i < 64; i++) begin
                        if (7'(i) == byte_cnt_q)     blk_d[i] = 8'h80;
                        else if (7'(i) > byte_cnt_q) blk_d[i] = 8'h00;
                    end
                    // Room left for the length field: this is the last block.
                    if (byte_cnt_q <= 7'd55) begin
                        final_d    = 1'b1;
                        len_pend_d = 1'b0;
                        for (int k = 0; k < 8; k++) blk_d[56+k] = 8'(len64 >> (56 - 8 * k));
                    end
                end
                state_d = StHash;
            end
            StLen: begin
                for (int i = 0; i < 64; i++) blk_d[i] = 8'h00;
                blk_d[0] = full_prev_q ? 8'h80 : 8'h00;
                for (int k = 0; k < 8; k++) blk_d[56+k] = 8'(len64 >> (56 - 8 * k));
                final_d    = 1'b1;
                len_pend_d = 1'b0;
                state_d    = StHash;
            end
            StHash: begin
                if (core_start) issued_d = 1'b1;
                if (core_done) begin
                    h_d      = core_out;
                    issued_d = 1'b0;
                    state_d  = len_pend_q ? StLen : (final_q ? StOut : StLoad);
                end
            end
            StOut: if (out_ready) begin
                h_d        = Iv;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                state_d    = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        in_ready   = in_ready_q;
        out_valid  = (state_q == StOut);
        out_hash   = out_valid ? h_q : '0;
        busy       = (state_q != StLoad) || (byte_cnt_q != 7'd0);
        core_start = (state_q == StHash) && !issued_q && core_ready;
    end

    assign core_ready = !core_run_q;
    assign core_done  = core_ready && !ready_prev_q;

    always_comb begin
        core_block = '0;
        for (int i = 0; i < 64; i++) core_block[511-8*i -: 8] = blk_q[i];
        t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
             + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[round_q] + win_q[0];
        t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
             + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        w_new = (rotr(win_q[14], 17) ^ rotr(win_q[14], 19) ^ (win_q[14] >> 10)) + win_q[9]
                + (rotr(win_q[1], 7) ^ rotr(win_q[1], 18) ^ (win_q[1] >> 3)) + win_q[0];
        core_out = '0;
        for (int i = 0; i < 8; i++) core_out[255-32*i -: 32] = core_init[255-32*i -: 32] + v_q[i];
    end

    // win_q slides so that win_q[0] is always the schedule word of the current round.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_run_q   <= 1'b0;
            round_q      <= '0;
            ready_prev_q <= 1'b1;
        end else begin
            ready_prev_q <= core_ready;
            if (core_start) begin
                core_run_q <= 1'b1;
                round_q    <= '0;
                for (int i = 0; i < 8; i++)  v_q[i]   <= core_init[255-32*i -: 32];
                for (int i = 0; i < 16; i++) win_q[i] <= core_block[511-32*i -: 32];
            end else if (core_run_q) begin
                for (int i = 0; i < 8; i++)  v_q[i]   <= v_d[i];
                for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
                win_q[15] <= w_new;
                round_q   <= round_q + 6'd1;
                if (round_q == 6'd63) core_run_q <= 1'b0;
            end
        end
    end
endmodule
